// File: rtl/timer_sched.sv
// timer_sched: four-channel bus-mapped timer with shared prescaler, serialized channel service and prioritized irq
module timer_sched #(
   parameter logic [15:0] BASE         = 16'hFF20,
   parameter logic [15:0] PRESCALE_RST = 16'h0031,
   parameter logic [15:0] RELOAD_RST   = 16'h03E7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_addr,
   input  logic        i_we,
   input  logic [7:0]  i_di,
   output logic [7:0]  o_do,
   output logic        o_irq,
   output logic [1:0]  o_irq_id,
   output logic        o_tick
);
   typedef enum logic {IDLE, SVC} state_t;
   state_t      r_state, w_state_nx;
   logic [1:0]  r_ptr, w_ptr_nx;
   logic [15:0] r_prescale, r_pcnt, w_eff;
   logic [3:0]  r_en, r_mode, r_pend, r_mask;
   logic [15:0] r_reload [4];
   logic [15:0] r_count [4];
   logic        w_sel, w_wr, w_wr_pre, w_hit;
   logic [3:0]  w_off, w_exp, w_en_wr, w_clr, w_act;

   assign w_sel    = i_addr[15:4] == BASE[15:4];
   assign w_off    = i_addr[3:0];
   assign w_wr     = i_we && w_sel;
   assign w_wr_pre = w_wr && w_off[3:1] == 3'b000;
   assign w_eff    = r_prescale < 16'd4 ? 16'd4 : r_prescale;
   assign o_tick   = r_pcnt == w_eff;
   assign w_act    = r_pend & r_mask;
   assign o_irq    = |w_act;
   assign o_irq_id = w_act[0] ? 2'd0 : w_act[1] ? 2'd1 : w_act[2] ? 2'd2 : w_act[3] ? 2'd3 : 2'd0;

   // prescaler counter: wraps on tick, restarts on any prescale write
   always_ff @(posedge clk) begin
      if (rst) r_pcnt <= 16'd0;
      else     r_pcnt <= (w_wr_pre || o_tick) ? 16'd0 : r_pcnt + 16'd1;
   end

   // service FSM state and channel pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
      end
   end

   // FSM next state: a tick starts a pass over channels 0..3, one per cycle
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      if (r_state == IDLE) begin
         if (o_tick) begin
            w_state_nx = SVC;
            w_ptr_nx   = 2'd0;
         end
      end else begin
         w_ptr_nx = r_ptr + 2'd1;
         if (r_ptr == 2'd3) w_state_nx = IDLE;
      end
   end

   // channel being serviced, its expiry, and bus-side enable/clear values
   always_comb begin
      w_hit   = r_state == SVC && r_en[r_ptr];
      w_exp   = (w_hit && r_count[r_ptr] == 16'd0) ? 4'b0001 << r_ptr : 4'b0000;
      w_en_wr = (w_wr && w_off == 4'd2) ? i_di[3:0] : r_en;
      w_clr   = (w_wr && w_off == 4'd4) ? i_di[3:0] : 4'b0000;
   end

   // register file and per-channel counters; expiry beats a same-cycle clear or enable write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale <= PRESCALE_RST;
         r_en       <= 4'h0;
         r_mode     <= 4'h0;
         r_pend     <= 4'h0;
         r_mask     <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            r_reload[i] <= RELOAD_RST;
            r_count[i]  <= 16'd0;
         end
      end else begin
         if (w_wr && w_off == 4'd0) r_prescale[7:0]  <= i_di;
         if (w_wr && w_off == 4'd1) r_prescale[15:8] <= i_di;
         if (w_wr && w_off == 4'd3) r_mode <= i_di[3:0];
         if (w_wr && w_off == 4'd5) r_mask <= i_di[3:0];
         r_en   <= w_en_wr & ~(w_exp & ~r_mode);
         r_pend <= (r_pend & ~w_clr) | w_exp;
         for (int i = 0; i < 4; i++) begin
            if (w_wr && w_off[3] && w_off[2:1] == 2'(i)) begin
               if (w_off[0]) r_reload[i][15:8] <= i_di;
               else          r_reload[i][7:0]  <= i_di;
            end
            if (w_en_wr[i] && !r_en[i])
               r_count[i] <= r_reload[i];
            else if (w_hit && r_ptr == 2'(i))
               r_count[i] <= r_count[i] == 16'd0 ? (r_mode[i] ? r_reload[i] : 16'd0) : r_count[i] - 16'd1;
         end
      end
   end

   // combinational bus read mux; anything unmapped reads zero
   always_comb begin
      o_do = 8'h00;
      if (w_sel) begin
         case (w_off)
            4'd0:    o_do = r_prescale[7:0];
            4'd1:    o_do = r_prescale[15:8];
            4'd2:    o_do = {4'h0, r_en};
            4'd3:    o_do = {4'h0, r_mode};
            4'd4:    o_do = {4'h0, r_pend};
            4'd5:    o_do = {4'h0, r_mask};
            4'd6:    o_do = {o_irq, 5'b0, o_irq_id};
            4'd7:    o_do = 8'h00;
            default: o_do = w_off[0] ? r_reload[w_off[2:1]][15:8] : r_reload[w_off[2:1]][7:0];
         endcase
      end
   end
endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
Four-channel memory-mapped timer controller on the 8-bit CPU bus (addr/we/di/do). A shared 16-bit prescaler generates a tick. A service FSM then walks the four channels and updates each one in turn through a single time-multiplexed 16-bit decrementer. Expiries are latched as pending flags, masked, and priority-encoded into an interrupt request with a channel id for the CPU.

Parameters:
BASE, 16'hFF20, base bus address of the 16-byte register window
PRESCALE_RST, 16'h0031, prescaler reset value (tick every 50 clk = 1 us at 50 MHz)
RELOAD_RST, 16'h03E7, reset reload value for every channel (1000 ticks = 1 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
addr  in  16  bus address
we  in  1  bus write strobe, one clk per write
di  in  8  bus write data
do  out  8  bus read data, combinational on addr
irq  out  1  interrupt request = |(pending & mask)
irq_id  out  2  lowest-numbered channel with a pending, unmasked expiry; 0 when irq=0
tick  out  1  one-clk prescaler tick strobe

Behaviour:
- Register map, offset from BASE:
  - +0/+1 PRESCALE lo/hi (RW)
  - +2 ENABLE[3:0] (RW)
  - +3 MODE[3:0] (RW): 1 = periodic, 0 = one-shot
  - +4 PENDING[3:0] (R; write-1-to-clear)
  - +5 MASK[3:0] (RW, reset 4'hF)
  - +6 STATUS (R): {irq, 5'b0, irq_id}
  - +8+2i / +9+2i RELOAD[i] lo/hi (RW)
  - Unused bits and unmapped addresses inside or outside the window read 0. Writes outside the window are ignored.
- Reset values: PRESCALE = PRESCALE_RST, RELOAD[i] = RELOAD_RST, ENABLE = MODE = PENDING = 0, MASK = F, all counts 0, prescaler counter 0, FSM IDLE. Outputs after reset: tick = 0, irq = 0, irq_id = 0.
- Prescaler:
  - Counts 0..PRESCALE. tick = 1 for the cycle in which counter == PRESCALE; the counter then wraps to 0.
  - The effective PRESCALE is max(PRESCALE, 4), so the tick period is at least 5 clk. The stored register value is not modified and reads back as written.
  - Writing either PRESCALE byte zeroes the prescaler counter.
- Channel enable and load:
  - A 0→1 write to ENABLE[i] loads count[i] = RELOAD[i] in the same edge.
  - Writing RELOAD[i] does not change a running count[i].
- Service FSM, states IDLE and SVC with a 2-bit pointer ptr:
  - IDLE + tick → SVC with ptr = 0.
  - In SVC, channel ptr is processed in one cycle; ptr increments; after ptr = 3 the FSM returns to IDLE.
  - Channel i is therefore updated on the edge ending cycle T+1+i, where T is the tick cycle. Its pending flag is visible at T+2+i.
- Processing channel i, only when ENABLE[i] = 1 (a disabled channel is skipped):
  - count[i] != 0: count[i] ← count[i] − 1.
  - count[i] == 0: PENDING[i] ← 1. If MODE[i] = 1, count[i] ← RELOAD[i]. If MODE[i] = 0, ENABLE[i] ← 0.
  - Result: period = RELOAD+1 ticks. RELOAD = 0 expires on every tick.
- Simultaneous events:
  - Expiry set and W1C clear of the same PENDING bit in one cycle: set wins.
  - CPU write to ENABLE in the same cycle a one-shot expiry clears it: the expiry clear wins for that bit; other bits take the written value.
  - ENABLE[i] written 0 before channel i is serviced: channel i is skipped for that pass.
  - A PENDING bit already set stays set on re-expiry. There is no count of missed expiries.
- irq and irq_id are combinational from the PENDING and MASK registers. Lowest index has priority.
- A synchronous rst mid-SVC returns every state element to its reset value on that edge. No partial update completes.

Test Plan:
- Reset: after rst, read +0/+1 = 31/00, +5 = 0F, +8/+9 = E7/03; irq = 0, tick = 0; tick first pulses 50 clk after rst deasserts.
- Periodic: PRESCALE = 4, RELOAD0 = 2, MODE = 1, ENABLE = 1. PENDING[0] sets 3 ticks (15 clk) after enable; irq = 1, irq_id = 0. Write +4 = 01 → irq = 0; PENDING[0] sets again 15 clk later.
- One-shot and priority: ch1 and ch3 one-shot with RELOAD = 0 and same tick. PENDING = 0A; ENABLE bits 1 and 3 read 0; irq_id = 1. MASK = 08 → irq_id = 3.
- Serialization: all 4 channels enabled with RELOAD = 0, tick at cycle T. PENDING bits rise at T+2, T+3, T+4, T+5 in channel order 0..3.
- Collisions: a W1C of PENDING[2] in the cycle channel 2 expires leaves PENDING[2] = 1. Writing PRESCALE = 1 gives a measured tick period of 5 clk.
- Reset mid-service: assert rst at T+2 with all channels enabled. Every register reads its reset value afterwards; FSM is IDLE; no PENDING bit is set.
